// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Optional feature macro: MULDIV_SIGNED_EN (signed operands, adds the FIX state).
package muldiv_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by shift-add multiply and restoring divide.
module muldiv_addsub
  import muldiv_pkg::*;
(
  input  logic [DATA_W:0] a,
  input  logic [DATA_W:0] b,
  input  logic            sub,
  output logic [DATA_W:0] sum
);

  // Two's-complement subtract folds into the add via invert and carry-in.
  assign sum = a + (sub ? ~b : b) + {{DATA_W{1'b0}}, sub};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide, one bit per cycle, HI/LO results.
// Optional feature macro: MULDIV_SIGNED_EN (signed operands via abs/fix-up).
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(ITER_COUNT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  iter_cnt;
  logic              op_q;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] acc_hi, acc_lo;
  logic              accept, div_zero_req, last_iter;
  logic [DATA_W:0]   as_a, as_b, as_sum;
  logic              as_sub;
  logic [DATA_W:0]   mul_pre;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [DATA_W-1:0] ld_a, ld_b;

`ifdef MULDIV_SIGNED_EN
  logic                signed_q, neg_res, neg_rem;
  logic [DATA_W-1:0]   fix_hi, fix_lo;
  logic [2*DATA_W-1:0] prod_neg;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
`endif

  assign accept       = start && ((state == IDLE) || (state == DONE));
  assign div_zero_req = (op == OP_DIV) && (src_b == '0);
  assign last_iter    = (iter_cnt == CNT_W'(ITER_COUNT - 1));

  muldiv_addsub u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  // One iteration: multiply keeps {acc_hi,acc_lo} as the 64-bit accumulator with
  // the multiplier shifting out of acc_lo; divide keeps the remainder in acc_hi
  // and shifts dividend bits out / quotient bits into acc_lo.
  always_comb begin
    as_sub  = (op_q == OP_DIV);
    as_b    = {1'b0, opb};
    as_a    = as_sub ? {acc_hi, acc_lo[DATA_W-1]} : {1'b0, acc_hi};
    mul_pre = acc_lo[0] ? as_sum : {1'b0, acc_hi};
    if (as_sub) begin
      // Remainder < divisor keeps a non-negative difference below 2^32, so
      // bit 32 of the 33-bit result is set only when the trial subtract fails.
      if (!as_sum[DATA_W]) begin
        step_hi = as_sum[DATA_W-1:0];
        step_lo = {acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        step_hi = as_a[DATA_W-1:0];
        step_lo = {acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_pre[DATA_W:1];
      step_lo = {mul_pre[0], acc_lo[DATA_W-1:1]};
    end
  end

  // Operand conditioning at load time: magnitudes for signed requests.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    ld_a = (signed_op && src_a[DATA_W-1]) ? -src_a : src_a;
    ld_b = (signed_op && src_b[DATA_W-1]) ? -src_b : src_b;
`else
    ld_a = src_a;
    ld_b = src_b;
`endif
  end

`ifdef MULDIV_SIGNED_EN
  // Sign fix-up applied to the unsigned core result on the FIX -> DONE edge.
  always_comb begin
    prod_neg = -{acc_hi, acc_lo};
    if (op_q == OP_MUL) begin
      {fix_hi, fix_lo} = neg_res ? prod_neg : {acc_hi, acc_lo};
    end else begin
      fix_lo = neg_res ? -acc_lo : acc_lo;
      fix_hi = neg_rem ? -acc_hi : acc_hi;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = div_zero_req ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (last_iter) begin
`ifdef MULDIV_SIGNED_EN
          state_nxt = signed_q ? FIX : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      FIX:     state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    busy = (state == RUN) || (state == FIX);
`else
    busy = (state == RUN);
`endif
    done = (state == DONE);
  end

  // Operand latch, iteration datapath and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= OP_MUL;
      opb         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      iter_cnt    <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef MULDIV_SIGNED_EN
      signed_q    <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else if (accept) begin
      op_q        <= op;
      opb         <= ld_b;
      acc_hi      <= '0;
      acc_lo      <= ld_a;
      iter_cnt    <= '0;
      div_by_zero <= div_zero_req;
      if (div_zero_req) begin
        hi <= '0;
        lo <= '0;
      end
`ifdef MULDIV_SIGNED_EN
      signed_q    <= signed_op;
      neg_res     <= signed_op && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      neg_rem     <= signed_op && src_a[DATA_W-1];
`endif
    end else begin
      case (state)
        RUN: begin
          acc_hi   <= step_hi;
          acc_lo   <= step_lo;
          iter_cnt <= iter_cnt + CNT_W'(1);
`ifdef MULDIV_SIGNED_EN
          if (last_iter && !signed_q) begin
`else
          if (last_iter) begin
`endif
            hi <= step_hi;
            lo <= step_lo;
          end
        end
`ifdef MULDIV_SIGNED_EN
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random ops
// against an arithmetic reference model. Honours MULDIV_SIGNED_EN if defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .signed_op   (signed_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, latency in edges after the
  // sampling edge until done is visible.
  task automatic model(input bit o, input bit s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output bit ez,
                       output int lat);
    logic [63:0] p;
    longint sa, sb, q, r;
    ez  = 1'b0;
    lat = 32;
    if (o && b == 32'd0) begin
      eh = '0; el = '0; ez = 1'b1; lat = 0;
    end else begin
      sa = 0; sb = 0; q = 0; r = 0;
`ifdef MULDIV_SIGNED_EN
      if (s) begin
        lat = 33;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (!o) begin
          q = sa * sb;
          eh = q[63:32]; el = q[31:0];
        end else begin
          q = sa / sb;
          r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end
      end else
`endif
      begin
        if (!o) begin
          p = {32'd0, a} * {32'd0, b};
          eh = p[63:32]; el = p[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    end
  endtask

  // Called away from a clock edge; returns #1 after the sampling edge.
  task automatic launch(input bit o, input bit s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; signed_op = s; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input bit o, input bit s,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    bit ez;
    int lat, cyc;
    model(o, s, a, b, eh, el, ez, lat);
    @(negedge clk);
    launch(o, s, a, b);
    check({tag, ".busy"}, {63'd0, busy}, {63'd0, (lat != 0)});
    wait_done(cyc);
    check({tag, ".lat"}, 64'(cyc), 64'(lat));
    check({tag, ".hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, ".lo"}, {32'd0, lo}, {32'd0, el});
    check({tag, ".dbz"}, {63'd0, div_by_zero}, {63'd0, ez});
  endtask

  initial begin
    int cyc, pre, seen;
    bit o, s;
    logic [31:0] a, b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", {63'd0, busy}, 64'd0);
    check("rst.done", {63'd0, done}, 64'd0);
    check("rst.dbz",  {63'd0, div_by_zero}, 64'd0);
    check("rst.hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic
    run_op("mul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_max.hi_const", {32'd0, hi}, 64'hFFFF_FFFE);
    check("mul_max.lo_const", {32'd0, lo}, 64'h0000_0001);
    run_op("div5_0", 1'b1, 1'b0, 32'd5, 32'd0);
    run_op("div100_7", 1'b1, 1'b0, 32'd100, 32'd7);
    check("div100_7.q", {32'd0, lo}, 64'd14);
    check("div100_7.r", {32'd0, hi}, 64'd2);

    // Start while busy is ignored; HI/LO hold previous result during RUN
    @(negedge clk);
    launch(1'b0, 1'b0, 32'd3, 32'd4);
    repeat (9) begin @(posedge clk); #1; end
    launch(1'b0, 1'b0, 32'd9, 32'd9);
    check("ign.busy", {63'd0, busy}, 64'd1);
    check("ign.hold", {hi, lo}, {32'd2, 32'd14});
    wait_done(cyc);
    check("ign.lat", 64'(cyc + 10), 64'd32);
    check("ign.res", {hi, lo}, {32'd0, 32'd12});

    // Start accepted in the DONE cycle
    launch(1'b0, 1'b0, 32'd9, 32'd9);
    check("dstart.busy", {63'd0, busy}, 64'd1);
    wait_done(cyc);
    check("dstart.lat", 64'(cyc), 64'd32);
    check("dstart.res", {hi, lo}, {32'd0, 32'd81});

    // Reset in the middle of a divide aborts with no done pulse
    @(negedge clk);
    launch(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (14) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort.busy", {63'd0, busy}, 64'd0);
    check("abort.done", {63'd0, done}, 64'd0);
    check("abort.hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    check("abort.nodone", 64'(seen), 64'd0);

    // Start coinciding with reset is ignored
    @(negedge clk);
    rst_n = 1'b0;
    launch(1'b0, 1'b0, 32'd7, 32'd7);
    rst_n = 1'b1;
    check("rststart.busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    check("rststart.idle", 64'(seen), 64'd0);

`ifdef MULDIV_SIGNED_EN
    run_op("smul", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
    check("smul.const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op("sdiv", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("sdiv.const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("sdiv_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("sdiv_ovf.const", {hi, lo}, {32'd0, 32'h8000_0000});
`endif

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      pre = int'($urandom_range(0, 7));
      if (pre == 0)      b = 32'd0;
      else if (pre < 3)  b = 32'($urandom_range(1, 15));
      else               b = $urandom;
      run_op($sformatf("rnd%0d", i), o, s, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
